// File: rtl/vec_dmem_ctrl_pkg.sv
// Shared types and constants for the vector data-memory controller.
// Included first so the array, interface users and top all agree on them.
package vec_mem_pkg;
    localparam int NUM_LANES = 5;
    localparam int DEF_DEPTH = 64;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        VSTORE = 2'd1,
        VLOAD  = 2'd2
    } state_e;
endpackage

// File: rtl/vec_dmem_ctrl_if.sv
// Request/response bundle between the core and the vector data memory.
// The core side is the master; the memory controller is the slave.
interface vec_dmem_ctrl_if;
    logic        we;
    logic        vwe;
    logic        vre;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] vwd_0, vwd_1, vwd_2, vwd_3, vwd_4;
    logic [31:0] rd;
    logic [31:0] vrd_0, vrd_1, vrd_2, vrd_3, vrd_4;
    logic        busy;
    logic        done;

    modport master (
        output we, vwe, vre, a, wd,
        output vwd_0, vwd_1, vwd_2, vwd_3, vwd_4,
        input  rd, vrd_0, vrd_1, vrd_2, vrd_3, vrd_4,
        input  busy, done
    );

    modport slave (
        input  we, vwe, vre, a, wd,
        input  vwd_0, vwd_1, vwd_2, vwd_3, vwd_4,
        output rd, vrd_0, vrd_1, vrd_2, vrd_3, vrd_4,
        output busy, done
    );
endinterface

// File: rtl/vec_dmem_array.sv
// Word array: two combinational read ports, one synchronous write port.
// Contents are deliberately not reset.
module vec_dmem_array #(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic [AW-1:0] i_raddr_s,
    output logic [31:0]   o_rdata_s,
    input  logic [AW-1:0] i_raddr_l,
    output logic [31:0]   o_rdata_l,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [31:0]   i_wdata
);
    logic [31:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    assign o_rdata_s = r_mem[i_raddr_s];
    assign o_rdata_l = r_mem[i_raddr_l];
endmodule

// File: rtl/vec_dmem_ctrl.sv
// Vector data-memory controller: zero-latency scalar access plus
// five-lane vector load/store sequenced one lane per clock.
module vec_dmem_ctrl
    import vec_mem_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int LANES = NUM_LANES
) (
    input  logic             clk,
    input  logic             reset,
    vec_dmem_ctrl_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(LANES);

    state_e        r_state;
    logic [LW-1:0] r_lane;
    logic [AW-1:0] r_base;
    logic          r_done;
    logic [31:0]   r_buf [LANES];
    logic [31:0]   r_vrd [LANES];

    logic [AW-1:0] w_idx;
    logic [AW-1:0] w_lane_idx;
    logic [31:0]   w_lane_rd;
    logic [31:0]   w_vwd [LANES];
    logic          w_last;
    logic          w_we;
    logic [AW-1:0] w_waddr;
    logic [31:0]   w_wdata;
    logic          w_unused;

    assign w_idx      = bus.a[AW+1:2];
    assign w_unused   = ^{bus.a[31:AW+2], bus.a[1:0]};
    assign w_lane_idx = r_base + AW'(r_lane);
    assign w_last     = (r_lane == LW'(LANES - 1));

    assign w_vwd[0] = bus.vwd_0;
    assign w_vwd[1] = bus.vwd_1;
    assign w_vwd[2] = bus.vwd_2;
    assign w_vwd[3] = bus.vwd_3;
    assign w_vwd[4] = bus.vwd_4;

    // Reset gates the write so an aborted store stops at the reset edge.
    assign w_we = reset &&
                  ((r_state == IDLE && bus.we && !bus.vwe && !bus.vre) ||
                   r_state == VSTORE);
    assign w_waddr = (r_state == VSTORE) ? w_lane_idx : w_idx;
    assign w_wdata = (r_state == VSTORE) ? r_buf[r_lane] : bus.wd;

    vec_dmem_array #(.DEPTH(DEPTH), .AW(AW)) u_array (
        .clk       (clk),
        .i_raddr_s (w_idx),
        .o_rdata_s (bus.rd),
        .i_raddr_l (w_lane_idx),
        .o_rdata_l (w_lane_rd),
        .i_we      (w_we),
        .i_waddr   (w_waddr),
        .i_wdata   (w_wdata)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
            r_lane  <= '0;
            r_base  <= '0;
            r_done  <= 1'b0;
            for (int k = 0; k < LANES; k++) begin
                r_buf[k] <= '0;
                r_vrd[k] <= '0;
            end
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (bus.vwe) begin
                        r_state <= VSTORE;
                        r_base  <= w_idx;
                        r_lane  <= '0;
                        for (int k = 0; k < LANES; k++)
                            r_buf[k] <= w_vwd[k];
                    end else if (bus.vre) begin
                        r_state <= VLOAD;
                        r_base  <= w_idx;
                        r_lane  <= '0;
                    end
                end
                VSTORE, VLOAD: begin
                    if (r_state == VLOAD) r_vrd[r_lane] <= w_lane_rd;
                    if (w_last) begin
                        r_state <= IDLE;
                        r_lane  <= '0;
                        r_done  <= 1'b1;
                    end else begin
                        r_lane <= r_lane + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.busy  = (r_state != IDLE);
    assign bus.done  = r_done;
    assign bus.vrd_0 = r_vrd[0];
    assign bus.vrd_1 = r_vrd[1];
    assign bus.vrd_2 = r_vrd[2];
    assign bus.vrd_3 = r_vrd[3];
    assign bus.vrd_4 = r_vrd[4];
endmodule

// File: tb/tb_vec_dmem_ctrl.sv
// Directed bench for vec_dmem_ctrl: scalar vector table plus
// hand-written vector store/load, wrap, priority and abort sequences.
module tb_vec_dmem_ctrl;
    import vec_mem_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    vec_dmem_ctrl_if bus ();

    vec_dmem_ctrl #(.DEPTH(64), .LANES(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic        we;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] ca;
        logic [31:0] exp;
    } svec_t;

    svec_t       tbl [6];
    logic [31:0] tv  [5];
    int          n_run;
    int          n_fail;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rdchk(input string name, input logic [31:0] addr,
                         input logic [31:0] exp);
        bus.a = addr;
        #1;
        chk(name, bus.rd, exp);
    endtask

    function automatic logic [31:0] vrd(input int k);
        case (k)
            0: return bus.vrd_0;
            1: return bus.vrd_1;
            2: return bus.vrd_2;
            3: return bus.vrd_3;
            default: return bus.vrd_4;
        endcase
    endfunction

    task automatic set_vwd();
        bus.vwd_0 = tv[0];
        bus.vwd_1 = tv[1];
        bus.vwd_2 = tv[2];
        bus.vwd_3 = tv[3];
        bus.vwd_4 = tv[4];
    endtask

    task automatic vec_op(input logic st, input logic [31:0] addr,
                          input string name);
        int nb;
        int nd;
        bus.vwe = st;
        bus.vre = !st;
        bus.a   = addr;
        set_vwd();
        tick();
        bus.vwe = 1'b0;
        bus.vre = 1'b0;
        nb = 0;
        nd = 0;
        for (int i = 0; i < 10; i++) begin
            if (bus.busy) nb++;
            if (bus.done) nd++;
            tick();
        end
        chk({name, " busy_cycles"}, 32'(nb), 32'd5);
        chk({name, " done_cycles"}, 32'(nd), 32'd1);
    endtask

    initial begin
        int nd;
        bit seen;
        n_run  = 0;
        n_fail = 0;

        tbl[0] = '{1'b1, 32'h10,  32'hDEADBEEF, 32'h10,  32'hDEADBEEF};
        tbl[1] = '{1'b1, 32'h13,  32'h12345678, 32'h10,  32'h12345678};
        tbl[2] = '{1'b1, 32'h104, 32'hCAFEF00D, 32'h04,  32'hCAFEF00D};
        tbl[3] = '{1'b1, 32'hFC,  32'h11111111, 32'hFC,  32'h11111111};
        tbl[4] = '{1'b0, 32'h10,  32'hFFFFFFFF, 32'h10,  32'h12345678};
        tbl[5] = '{1'b1, 32'h00,  32'hA5A5A5A5, 32'h100, 32'hA5A5A5A5};

        bus.we  = 1'b0;
        bus.vwe = 1'b0;
        bus.vre = 1'b0;
        bus.a   = '0;
        bus.wd  = '0;
        for (int k = 0; k < 5; k++) tv[k] = '0;
        set_vwd();

        reset = 1'b0;
        tick();
        tick();
        chk("reset busy", {31'd0, bus.busy}, 32'd0);
        chk("reset done", {31'd0, bus.done}, 32'd0);
        chk("reset vrd0", vrd(0), 32'd0);
        chk("reset vrd4", vrd(4), 32'd0);
        reset = 1'b1;
        tick();

        for (int i = 0; i < 6; i++) begin
            bus.we = tbl[i].we;
            bus.a  = tbl[i].a;
            bus.wd = tbl[i].wd;
            tick();
            bus.we = 1'b0;
            chk($sformatf("scalar%0d busy", i), {31'd0, bus.busy}, 32'd0);
            rdchk($sformatf("scalar%0d rd", i), tbl[i].ca, tbl[i].exp);
        end

        for (int k = 0; k < 5; k++) tv[k] = 32'(k + 1);
        vec_op(1'b1, 32'h20, "vst");
        for (int k = 0; k < 5; k++)
            rdchk($sformatf("vst word%0d", 8 + k), 32'(32'h20 + 4 * k),
                  32'(k + 1));

        vec_op(1'b0, 32'h20, "vld");
        for (int k = 0; k < 5; k++)
            chk($sformatf("vld vrd%0d", k), vrd(k), 32'(k + 1));

        for (int k = 0; k < 5; k++) tv[k] = 32'(32'h10 + k);
        vec_op(1'b1, 32'h40, "vst2");
        for (int k = 0; k < 5; k++)
            chk($sformatf("vst2 vrd%0d hold", k), vrd(k), 32'(k + 1));
        rdchk("vst2 word16", 32'h40, 32'h10);

        for (int k = 0; k < 5; k++) tv[k] = 32'(32'hA + k);
        vec_op(1'b1, 32'hF8, "wrap");
        rdchk("wrap word62", 32'hF8, 32'hA);
        rdchk("wrap word63", 32'hFC, 32'hB);
        rdchk("wrap word0",  32'h00, 32'hC);
        rdchk("wrap word1",  32'h04, 32'hD);
        rdchk("wrap word2",  32'h08, 32'hE);
        vec_op(1'b0, 32'hF8, "wrapld");
        for (int k = 0; k < 5; k++)
            chk($sformatf("wrapld vrd%0d", k), vrd(k), 32'(32'hA + k));

        for (int k = 0; k < 5; k++) tv[k] = 32'(32'h21 + k);
        bus.vwe = 1'b1;
        bus.vre = 1'b1;
        bus.we  = 1'b1;
        bus.a   = 32'h60;
        bus.wd  = 32'h99;
        set_vwd();
        tick();
        bus.vwe   = 1'b0;
        bus.vre   = 1'b0;
        bus.a     = 32'h20;
        bus.wd    = 32'h00000BAD;
        bus.vwd_0 = 32'hFFFFFFFF;
        for (int i = 0; i < 4; i++) tick();
        bus.we = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (!bus.busy) break;
            tick();
        end
        chk("prio idle", {31'd0, bus.busy}, 32'd0);
        rdchk("busy we ignored", 32'h20, 32'd1);
        for (int k = 0; k < 5; k++)
            rdchk($sformatf("prio word%0d", 24 + k), 32'(32'h60 + 4 * k),
                  32'(32'h21 + k));
        chk("prio vre dropped", vrd(0), 32'hA);

        for (int k = 0; k < 5; k++) tv[k] = 32'(32'h31 + k);
        bus.vwe = 1'b1;
        bus.a   = 32'hC0;
        set_vwd();
        tick();
        bus.vwe = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (bus.done) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        chk("b2b done seen", {31'd0, seen}, 32'd1);
        bus.we = 1'b1;
        bus.a  = 32'h30;
        bus.wd = 32'h77;
        tick();
        bus.we = 1'b0;
        rdchk("b2b scalar", 32'h30, 32'h77);
        rdchk("b2b vec word52", 32'hD0, 32'h35);

        for (int k = 0; k < 5; k++) tv[k] = 32'(32'hC0 + k);
        vec_op(1'b1, 32'h80, "pre");
        for (int k = 0; k < 5; k++) tv[k] = 32'(32'hB0 + k);
        bus.vwe = 1'b1;
        bus.a   = 32'h80;
        set_vwd();
        tick();
        bus.vwe = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        chk("abort busy", {31'd0, bus.busy}, 32'd0);
        nd = 0;
        for (int i = 0; i < 8; i++) begin
            if (bus.done) nd++;
            tick();
        end
        chk("abort no done", 32'(nd), 32'd0);
        rdchk("abort lane0", 32'h80, 32'hB0);
        rdchk("abort lane1", 32'h84, 32'hB1);
        rdchk("abort lane2", 32'h88, 32'hC2);
        rdchk("abort lane3", 32'h8C, 32'hC3);
        rdchk("abort lane4", 32'h90, 32'hC4);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule

// File: doc/vec_dmem_ctrl.md
VEC_DMEM_CTRL -- requirements
Module: vec_dmem_ctrl

Interface
REQ-001 Parameter DEPTH, default 64: number of 32-bit words in the data array (power of two).
REQ-002 Parameter LANES, default 5: words per vector transfer.
REQ-003 clk  in  1  sole clock, all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-low reset (reset=0 resets on the next rising edge of clk).
REQ-005 we  in  1  scalar write request.
REQ-006 vwe  in  1  vector store request.
REQ-007 vre  in  1  vector load request.
REQ-008 a  in  32  byte address; word index = a[log2(DEPTH)+1:2], a[1:0] and upper bits ignored.
REQ-009 wd  in  32  scalar write data.
REQ-010 vwd_0 .. vwd_4  in  32 each  vector store lane data.
REQ-011 rd  out  32  scalar read data.
REQ-012 vrd_0 .. vrd_4  out  32 each  vector load lane results.
REQ-013 busy  out  1  high while a vector transfer is in progress.
REQ-014 done  out  1  one-cycle completion pulse for a vector transfer.

Function
REQ-015 States SHALL be IDLE, VSTORE, VLOAD; busy = (state != IDLE).
REQ-016 rd SHALL be combinational: mem[word index of a], valid in every state, including during busy.
REQ-017 In IDLE, request priority SHALL be vwe > vre > we; lower-priority requests in the same cycle are dropped.
REQ-018 Scalar write: in IDLE with we=1 and vwe=vre=0, mem[idx] <= wd at that edge; zero-latency, no busy.
REQ-019 Vector accept: in IDLE with vwe=1 (or vre=1), capture base index and, for stores, all five vwd lanes into an internal buffer; lane counter <= 0; go VSTORE (or VLOAD).
REQ-020 VSTORE: one lane per edge, mem[(base+k) mod DEPTH] <= buffer[k], k=0..4 on the 5 edges after accept.
REQ-021 VLOAD: one lane per edge, vrd_k <= mem[(base+k) mod DEPTH], k=0..4 on the 5 edges after accept.
REQ-022 On the edge handling lane 4, state SHALL return to IDLE and done SHALL be 1 for exactly the following cycle; busy is high for exactly 5 cycles.
REQ-023 Address wrap: lane indices SHALL wrap modulo DEPTH (base=DEPTH-2 -> words 62,63,0,1,2 for DEPTH=64).
REQ-024 we, vwe, vre, a, wd, vwd_* SHALL be ignored while busy=1; the core stalls on busy.
REQ-025 A new request presented in the cycle done=1 (state IDLE) SHALL be accepted normally (back-to-back).
REQ-026 vrd_* SHALL hold their values until overwritten by a later vector load; unaffected by stores.
REQ-027 VLOAD reads SHALL see memory as of that edge (a lane written by an earlier completed store is visible).

Reset
REQ-028 On reset=0: state=IDLE, lane counter=0, busy=0, done=0, vrd_*=0, store buffer=0.
REQ-029 Memory contents SHALL NOT be reset.
REQ-030 Reset mid-transfer SHALL abort: lanes already written remain, remaining lanes not written, no done pulse.

Structure
REQ-031 Package vec_mem_pkg SHALL hold the state enum, LANES constant and default DEPTH.
REQ-032 Sub-module vec_dmem_array: DEPTH x 32 array, two combinational read ports (scalar, lane), one synchronous write port.

Verification
REQ-033 Scalar: we=1, a=0x10, wd=0xDEADBEEF -> next cycle rd=0xDEADBEEF with a=0x10, busy stays 0.
REQ-034 Vector store: vwe=1, a=0x20, vwd=1,2,3,4,5 -> busy 5 cycles, done 1 cycle, words 8..12 read back 1..5.
REQ-035 Vector load after REQ-034: vre=1, a=0x20 -> after done, vrd_0..4 = 1..5; a second store leaves vrd unchanged.
REQ-036 Wrap: vwe=1, a=0xF8 (DEPTH=64), vwd=A..E -> words 62,63,0,1,2 = A..E.
REQ-037 Priority/ignore: vwe=vre=we=1 same cycle -> only vector store runs, scalar write dropped; we=1 during busy -> memory unchanged.
REQ-038 Reset abort: reset=0 two cycles after vector-store accept -> lanes 0,1 written, lanes 2..4 untouched, done never pulses, busy=0.
